// File: rtl/bfp_fp_convert_if.sv
// Bundle of the BFP converter's data-path signals: the FP32 collect side,
// the aligned-mantissa emit side and the accumulator-to-FP return path.
interface bfp_fp_convert_if #(
  parameter int V    = 8,
  parameter int P    = 4,
  parameter int BIT  = 32,
  parameter int FPM  = 23,
  parameter int BFPM = 4
);
  localparam int EW = BIT - FPM - 1;
  localparam int MW = BFPM + 2;
  localparam int PW = 2 * MW + $clog2(V);
  localparam int XW = EW + 2;

  // Collect side
  logic               in_valid;
  logic               in_ready;
  logic [P*BIT-1:0]   in_vals;
  // Emit side
  logic               bfp_valid;
  logic [P*MW-1:0]    bfp_mants;
  logic [EW-1:0]      bfp_exp;
  logic               bfp_last;
  // Return path
  logic               prod_valid;
  logic [PW-1:0]      prod;
  logic [XW-1:0]      prod_exp;
  logic               fp_valid;
  logic [BIT-1:0]     fp_out;

  modport slave (
    input  in_valid, in_vals, prod_valid, prod, prod_exp,
    output in_ready, bfp_valid, bfp_mants, bfp_exp, bfp_last, fp_valid, fp_out
  );

  modport master (
    output in_valid, in_vals, prod_valid, prod, prod_exp,
    input  in_ready, bfp_valid, bfp_mants, bfp_exp, bfp_last, fp_valid, fp_out
  );
endinterface

// File: rtl/bfp_fp_convert.sv
// FP32 -> block-floating-point converter with an independent BFP -> FP32
// return path. A V-element vector arrives as V/P beats, the largest exponent
// is tracked while collecting, then each beat is re-emitted as signed
// mantissas aligned to that shared exponent.
module bfp_fp_convert #(
  parameter int V    = 8,
  parameter int P    = 4,
  parameter int BIT  = 32,
  parameter int FPM  = 23,
  parameter int BFPM = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  bfp_fp_convert_if.slave       bus
);
  localparam int EW   = BIT - FPM - 1;
  localparam int MW   = BFPM + 2;
  localparam int PW   = 2 * MW + $clog2(V);
  localparam int NB   = V / P;
  localparam int NBW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int EMAX = (1 << EW) - 1;

  typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

  state_t             state_q;
  logic [NBW-1:0]     beat_q;
  logic [NBW-1:0]     idx_q;
  logic [EW-1:0]      max_exp_q;
  logic [P*BIT-1:0]   buf_q [NB];
  logic               bfp_valid_q;
  logic [P*MW-1:0]    bfp_mants_q;
  logic [EW-1:0]      bfp_exp_q;
  logic               bfp_last_q;
  logic               fp_valid_q;
  logic [BIT-1:0]     fp_out_q;

  logic [EW-1:0]      beat_max_d;
  logic [P*MW-1:0]    bfp_mants_d;
  logic               prod_s;
  logic [PW-1:0]      prod_m;
  int                 lead_k;
  int                 exp_i;
  logic [FPM-1:0]     frac;
  logic [BIT-1:0]     fp_out_d;

  // Align one FP32 lane to the shared exponent: hidden one plus the top BFPM
  // fraction bits, shifted right (truncating) and negated for negative inputs.
  function automatic logic [MW-1:0] conv(input logic [BIT-1:0] x,
                                         input logic [EW-1:0]  mx);
    logic [EW-1:0] e;
    logic [EW-1:0] sh;
    logic [MW-1:0] mag;
    e   = x[BIT-2:FPM];
    sh  = mx - e;
    mag = MW'({1'b1, x[FPM-1:FPM-BFPM]});
    if (e == '0 || sh >= EW'(BFPM + 1)) mag = '0;
    else                                mag = mag >> sh;
    return x[BIT-1] ? -mag : mag;
  endfunction

  // Running maximum of the stored exponent and every lane of the incoming beat.
  // NOTE: default assignment first so no path leaves the variable unassigned (no latch).
  always_comb begin
    beat_max_d = max_exp_q;
    for (int j = 0; j < P; j++) begin
      if (bus.in_vals[j*BIT+FPM +: EW] > beat_max_d)
        beat_max_d = bus.in_vals[j*BIT+FPM +: EW];
    end
  end

  // Aligned mantissas for the beat currently being emitted.
  always_comb begin
    bfp_mants_d = '0;
    for (int j = 0; j < P; j++)
      bfp_mants_d[j*MW +: MW] = conv(buf_q[idx_q][j*BIT +: BIT], max_exp_q);
  end

  // Return path: normalise the signed accumulator into an IEEE word.
  always_comb begin
    prod_s = bus.prod[PW-1];
    prod_m = prod_s ? -bus.prod : bus.prod;
    lead_k = 0;
    for (int i = 0; i < PW; i++)
      if (prod_m[i]) lead_k = i;
    exp_i = int'($signed(bus.prod_exp)) + lead_k - 2 * BFPM;
    frac  = FPM'({prod_m, {FPM{1'b0}}} >> lead_k);
    if (prod_m == '0)      fp_out_d = '0;
    else if (exp_i <= 0)   fp_out_d = {prod_s, {(BIT-1){1'b0}}};
    else if (exp_i >= EMAX) fp_out_d = {prod_s, {EW{1'b1}}, {FPM{1'b0}}};
    else                   fp_out_d = {prod_s, EW'(exp_i), frac};
  end

  // Collect/emit state machine with registered mantissa outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= COLLECT;
      beat_q      <= '0;
      idx_q       <= '0;
      max_exp_q   <= '0;
      // NOTE: the beat buffer is small and must not leak a discarded
      // partial vector, so it is reset like ordinary registers.
      for (int b = 0; b < NB; b++) buf_q[b] <= '0;
      bfp_valid_q <= 1'b0;
      bfp_mants_q <= '0;
      bfp_exp_q   <= '0;
      bfp_last_q  <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          bfp_valid_q <= 1'b0;
          bfp_last_q  <= 1'b0;
          if (bus.in_valid) begin
            buf_q[beat_q] <= bus.in_vals;
            max_exp_q     <= beat_max_d;
            if (beat_q == NBW'(NB - 1)) begin
              beat_q  <= '0;
              idx_q   <= '0;
              state_q <= EMIT;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        EMIT: begin
          bfp_valid_q <= 1'b1;
          bfp_mants_q <= bfp_mants_d;
          bfp_exp_q   <= max_exp_q;
          bfp_last_q  <= (idx_q == NBW'(NB - 1));
          if (idx_q == NBW'(NB - 1)) begin
            idx_q     <= '0;
            beat_q    <= '0;
            max_exp_q <= '0;
            state_q   <= COLLECT;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  // Return path register: valid follows prod_valid, result holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fp_valid_q <= 1'b0;
      fp_out_q   <= '0;
    end else begin
      fp_valid_q <= bus.prod_valid;
      if (bus.prod_valid) fp_out_q <= fp_out_d;
    end
  end

  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.bfp_valid = bfp_valid_q;
  assign bus.bfp_mants = bfp_mants_q;
  assign bus.bfp_exp   = bfp_exp_q;
  assign bus.bfp_last  = bfp_last_q;
  assign bus.fp_valid  = fp_valid_q;
  assign bus.fp_out    = fp_out_q;
endmodule

// File: tb/tb_bfp_fp_convert.sv
// Directed bench for bfp_fp_convert: collect/emit of two vectors, a
// mid-vector reset, and return-path normal/sign/zero/underflow/overflow cases.
module tb_bfp_fp_convert;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  bfp_fp_convert_if bus ();

  bfp_fp_convert dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] m4(input logic [5:0] l3, input logic [5:0] l2,
                                     input logic [5:0] l1, input logic [5:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  task automatic ret(input string tag, input logic [14:0] p, input logic [9:0] pe,
                     input logic [31:0] exp);
    bus.prod_valid = 1'b1;
    bus.prod       = p;
    bus.prod_exp   = pe;
    tick();
    chk({tag, "_valid"}, 32'(bus.fp_valid), 32'd1);
    chk(tag, bus.fp_out, exp);
  endtask

  localparam logic [127:0] BEAT_POS = {32'h40900000, 32'h40600000, 32'h40200000, 32'h3FC00000};
  localparam logic [127:0] BEAT_NEG = {32'h40900000, 32'h40600000, 32'h40200000, 32'hBFC00000};

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_vals    = '0;
    bus.prod_valid = 1'b0;
    bus.prod       = '0;
    bus.prod_exp   = '0;
    tick();
    tick();
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_bfp_valid", 32'(bus.bfp_valid), 32'd0);
    chk("rst_bfp_mants", 32'(bus.bfp_mants), 32'd0);
    chk("rst_bfp_exp",   32'(bus.bfp_exp),   32'd0);
    chk("rst_bfp_last",  32'(bus.bfp_last),  32'd0);
    chk("rst_fp_valid",  32'(bus.fp_valid),  32'd0);
    chk("rst_fp_out",    bus.fp_out,         32'd0);
    reset = 1'b1;
    tick();

    // Vector 1: {1.5,2.5,3.5,4.5} then {-1.5,2.5,3.5,4.5}; return path runs alongside.
    bus.in_valid = 1'b1;
    bus.in_vals  = BEAT_POS;
    tick();
    chk("v1_ready_beat0", 32'(bus.in_ready), 32'd1);
    bus.in_vals  = BEAT_NEG;
    tick();
    chk("v1_ready_emit",  32'(bus.in_ready),  32'd0);
    chk("v1_valid_early", 32'(bus.bfp_valid), 32'd0);
    bus.in_valid   = 1'b0;
    bus.prod_valid = 1'b1;
    bus.prod       = 15'd1312;
    bus.prod_exp   = 10'd131;
    tick();
    chk("v1_b0_valid", 32'(bus.bfp_valid), 32'd1);
    chk("v1_b0_mants", 32'(bus.bfp_mants), 32'(m4(6'd18, 6'd14, 6'd10, 6'd6)));
    chk("v1_b0_exp",   32'(bus.bfp_exp),   32'd129);
    chk("v1_b0_last",  32'(bus.bfp_last),  32'd0);
    chk("ret_82_valid", 32'(bus.fp_valid), 32'd1);
    chk("ret_82",       bus.fp_out,        32'h42A40000);
    bus.prod = 15'h7FFF & 15'(-1312);
    tick();
    chk("v1_b1_valid", 32'(bus.bfp_valid), 32'd1);
    chk("v1_b1_mants", 32'(bus.bfp_mants), 32'(m4(6'd18, 6'd14, 6'd10, 6'b111010)));
    chk("v1_b1_exp",   32'(bus.bfp_exp),   32'd129);
    chk("v1_b1_last",  32'(bus.bfp_last),  32'd1);
    chk("ret_m82",     bus.fp_out,         32'hC2A40000);
    bus.prod_valid = 1'b0;
    tick();
    chk("v1_done_valid", 32'(bus.bfp_valid), 32'd0);
    chk("v1_done_ready", 32'(bus.in_ready),  32'd1);
    chk("ret_idle_valid", 32'(bus.fp_valid), 32'd0);
    chk("ret_hold",       bus.fp_out,        32'hC2A40000);

    // Vector 2: zero, denormal, 1.0, -8.0, deep shifts; max exponent 130.
    // Junk with a huge exponent is held on in_vals during EMIT and must be ignored.
    bus.in_valid = 1'b1;
    bus.in_vals  = {32'h40800000, 32'h41000000, 32'h3F800000, 32'h00000000};
    tick();
    bus.in_vals  = {32'h3F000000, 32'h3E000000, 32'hC1000000, 32'h00400000};
    tick();
    bus.in_vals  = {4{32'h7F000000}};
    tick();
    chk("v2_b0_mants", 32'(bus.bfp_mants), 32'(m4(6'd8, 6'd16, 6'd2, 6'd0)));
    chk("v2_b0_exp",   32'(bus.bfp_exp),   32'd130);
    chk("v2_b0_last",  32'(bus.bfp_last),  32'd0);
    tick();
    chk("v2_b1_mants", 32'(bus.bfp_mants), 32'(m4(6'd1, 6'd0, 6'b110000, 6'd0)));
    chk("v2_b1_exp",   32'(bus.bfp_exp),   32'd130);
    chk("v2_b1_last",  32'(bus.bfp_last),  32'd1);
    bus.in_valid = 1'b0;
    tick();
    chk("v2_done_valid", 32'(bus.bfp_valid), 32'd0);

    // Return path boundary cases.
    ret("ret_zero",      15'd0,     10'd131, 32'h00000000);
    ret("ret_inf",       15'd1312,  10'd300, 32'h7F800000);
    ret("ret_max_norm",  15'd1,     10'd262, 32'h7F000000);
    ret("ret_inf_edge",  15'd1,     10'd263, 32'h7F800000);
    ret("ret_uflow_pos", 15'd1,     10'd8,   32'h00000000);
    ret("ret_uflow_neg", 15'h7FFF,  10'd8,   32'h80000000);
    ret("ret_min_norm",  15'd1,     10'd9,   32'h00800000);
    ret("ret_most_neg",  15'h4000,  10'd121, 32'hBF800000);
    ret("ret_trunc",     15'h3FFF,  10'd122, 32'h3FFFFC00);
    bus.prod_valid = 1'b0;
    tick();
    chk("ret_hold2", bus.fp_out, 32'h3FFFFC00);

    // Mid-vector reset: a large-exponent first beat is discarded.
    bus.in_valid = 1'b1;
    bus.in_vals  = {4{32'h47000000}};
    tick();
    bus.in_valid = 1'b0;
    reset        = 1'b0;
    #1;
    chk("mid_rst_ready",  32'(bus.in_ready), 32'd1);
    chk("mid_rst_fp_out", bus.fp_out,        32'd0);
    tick();
    reset        = 1'b1;
    tick();
    bus.in_valid = 1'b1;
    bus.in_vals  = BEAT_POS;
    tick();
    tick();
    chk("v3_ready_emit", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    tick();
    chk("v3_b0_valid", 32'(bus.bfp_valid), 32'd1);
    chk("v3_b0_mants", 32'(bus.bfp_mants), 32'(m4(6'd18, 6'd14, 6'd10, 6'd6)));
    chk("v3_b0_exp",   32'(bus.bfp_exp),   32'd129);
    chk("v3_b0_last",  32'(bus.bfp_last),  32'd0);
    tick();
    chk("v3_b1_mants", 32'(bus.bfp_mants), 32'(m4(6'd18, 6'd14, 6'd10, 6'd6)));
    chk("v3_b1_last",  32'(bus.bfp_last),  32'd1);
    tick();
    chk("v3_done_valid", 32'(bus.bfp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
